// File: rtl/apb_master_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_ctrl_if
// Description : Bundle of the request/response handshake and the APB bus
//               signals used by apb_master_ctrl.
//               master modport : controller side (drives APB + response)
//               slave modport  : environment side (requester + APB slaves)
// Ports       : req_valid/ready/write/addr/wdata   request channel
//               rsp_valid/rdata/err                 response pulse
//               psel/penable/pwrite/paddr/pwdata    APB outputs
//               prdata/pready/pslverr               per-slave APB returns
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_master_ctrl_if #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4
);
    logic                         req_valid;
    logic                         req_ready;
    logic                         req_write;
    logic [ADDR_W-1:0]            req_addr;
    logic [DATA_W-1:0]            req_wdata;
    logic                         rsp_valid;
    logic [DATA_W-1:0]            rsp_rdata;
    logic                         rsp_err;
    logic [NUM_SLAVES-1:0]        psel;
    logic                         penable;
    logic                         pwrite;
    logic [ADDR_W-1:0]            paddr;
    logic [DATA_W-1:0]            pwdata;
    logic [NUM_SLAVES*DATA_W-1:0] prdata;
    logic [NUM_SLAVES-1:0]        pready;
    logic [NUM_SLAVES-1:0]        pslverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               psel, penable, pwrite, paddr, pwdata
    );
endinterface
`default_nettype wire

// File: rtl/apb_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_ctrl
// Description : APB master controller. Converts a valid/ready request into
//               APB SETUP/ACCESS transfers on one of NUM_SLAVES slaves,
//               decoding the slave from the upper SEL_W address bits, with
//               read-data return, pslverr forwarding, wait-state timeout and
//               back-to-back transfers.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous active-low reset
//               bus  - apb_master_ctrl_if.master (request, response, APB)
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_ctrl #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4,
    parameter int SEL_W      = 2,
    parameter int TIMEOUT    = 16
) (
    input  wire                clk,
    input  wire                rst,
    apb_master_ctrl_if.master  bus
);

    localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LIM = c_CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t              r_state;
    logic [SEL_W-1:0]    r_idx;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_err_pend;   // decode error accepted back-to-back, response owed

    logic [SEL_W-1:0]      w_req_idx;
    logic                  w_idx_ok;
    logic [NUM_SLAVES-1:0] w_req_psel;
    logic                  w_sel_pready;
    logic                  w_sel_pslverr;
    logic [DATA_W-1:0]     w_sel_prdata;
    logic                  w_timeout;
    logic                  w_done;
    logic                  w_abort;
    logic                  w_req_ready;
    logic                  w_accept;

    assign w_req_idx = bus.req_addr[ADDR_W-1 -: SEL_W];
    assign w_idx_ok  = ({1'b0, w_req_idx} < (SEL_W+1)'(NUM_SLAVES));

    // Slave returns are muxed by the latched index; the request index is
    // expanded to a one-hot select. Loops avoid out-of-range part selects
    // when 2**SEL_W exceeds NUM_SLAVES.
    always_comb begin
        w_sel_pready  = 1'b0;
        w_sel_pslverr = 1'b0;
        w_sel_prdata  = '0;
        w_req_psel    = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_idx == SEL_W'(i)) begin
                w_sel_pready  = bus.pready[i];
                w_sel_pslverr = bus.pslverr[i];
                w_sel_prdata  = bus.prdata[i*DATA_W +: DATA_W];
            end
            if (w_req_idx == SEL_W'(i)) begin
                w_req_psel[i] = 1'b1;
            end
        end
    end

    assign w_timeout = (TIMEOUT > 0) && (r_cnt == c_CNT_LIM);
    assign w_done    = (r_state == S_ACCESS) && w_sel_pready;
    assign w_abort   = (r_state == S_ACCESS) && !w_sel_pready && w_timeout;

    // While an owed decode-error response is being issued, a further request
    // is held off so that two responses can never land in the same cycle.
    always_comb begin
        w_req_ready = 1'b0;
        case (r_state)
            S_IDLE:   w_req_ready = !r_err_pend;
            S_ACCESS: w_req_ready = w_sel_pready;
            default:  w_req_ready = 1'b0;
        endcase
    end

    assign bus.req_ready = w_req_ready;
    assign w_accept      = bus.req_valid && w_req_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_err_pend    <= 1'b0;
            bus.psel      <= '0;
            bus.penable   <= 1'b0;
            bus.pwrite    <= 1'b0;
            bus.paddr     <= '0;
            bus.pwdata    <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;

            if (r_state == S_IDLE && r_err_pend) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_err   <= 1'b1;
                r_err_pend    <= 1'b0;
            end

            if (r_state == S_SETUP) begin
                bus.penable <= 1'b1;
                r_cnt       <= '0;
                r_state     <= S_ACCESS;
            end else if (r_state == S_IDLE || w_done) begin
                if (w_done) begin
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_err   <= w_sel_pslverr;
                    bus.rsp_rdata <= (!bus.pwrite && !w_sel_pslverr) ? w_sel_prdata : '0;
                end
                bus.penable <= 1'b0;
                if (w_accept && w_idx_ok) begin
                    r_state    <= S_SETUP;
                    r_idx      <= w_req_idx;
                    bus.psel   <= w_req_psel;
                    bus.paddr  <= bus.req_addr;
                    bus.pwdata <= bus.req_wdata;
                    bus.pwrite <= bus.req_write;
                end else begin
                    r_state  <= S_IDLE;
                    bus.psel <= '0;
                    if (w_accept) begin
                        // Decode error: respond next cycle, or one cycle later
                        // if this cycle's completion already owns that slot.
                        if (w_done) begin
                            r_err_pend <= 1'b1;
                        end else begin
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                        end
                    end
                end
            end else if (w_abort) begin
                bus.psel      <= '0;
                bus.penable   <= 1'b0;
                r_state       <= S_IDLE;
                bus.rsp_valid <= 1'b1;
                bus.rsp_err   <= 1'b1;
            end else if (r_state == S_ACCESS) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_state <= S_IDLE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master_ctrl
// Description : Directed self-checking bench for apb_master_ctrl. Two
//               instances: A (4 slaves, TIMEOUT=4) and B (3 slaves, timeout
//               disabled) for the decode-error cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    apb_master_ctrl_if #(.ADDR_W(16), .DATA_W(32), .NUM_SLAVES(4)) ifa ();
    apb_master_ctrl_if #(.ADDR_W(16), .DATA_W(32), .NUM_SLAVES(3)) ifb ();

    apb_master_ctrl #(.ADDR_W(16), .DATA_W(32), .NUM_SLAVES(4), .SEL_W(2), .TIMEOUT(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    apb_master_ctrl #(.ADDR_W(16), .DATA_W(32), .NUM_SLAVES(3), .SEL_W(2), .TIMEOUT(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic req_a(input logic wr, input logic [15:0] a, input logic [31:0] d);
        ifa.req_valid = 1'b1;
        ifa.req_write = wr;
        ifa.req_addr  = a;
        ifa.req_wdata = d;
    endtask

    task automatic req_b(input logic wr, input logic [15:0] a, input logic [31:0] d);
        ifb.req_valid = 1'b1;
        ifb.req_write = wr;
        ifb.req_addr  = a;
        ifb.req_wdata = d;
    endtask

    initial begin
        rst = 1'b0;
        ifa.req_valid = 0; ifa.req_write = 0; ifa.req_addr = '0; ifa.req_wdata = '0;
        ifa.prdata = '0; ifa.pready = '0; ifa.pslverr = '0;
        ifb.req_valid = 0; ifb.req_write = 0; ifb.req_addr = '0; ifb.req_wdata = '0;
        ifb.prdata = '0; ifb.pready = '0; ifb.pslverr = '0;

        // ---------------- reset state ----------------
        #7;
        chk("rst_psel",    ifa.psel,      4'b0000);
        chk("rst_penable", ifa.penable,   1'b0);
        chk("rst_paddr",   ifa.paddr,     16'h0000);
        chk("rst_rsp",     ifa.rsp_valid, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        tick;
        chk("idle_ready", ifa.req_ready, 1'b1);

        // ---------------- single write, slave 1, zero wait ----------------
        ifa.pready = 4'b1111;
        req_a(1'b1, 16'h4010, 32'hDEADBEEF);
        tick;                                   // SETUP
        ifa.req_valid = 1'b0;
        #1;
        chk("wr_setup_psel",  ifa.psel,    4'b0010);
        chk("wr_setup_pen",   ifa.penable, 1'b0);
        chk("wr_setup_addr",  ifa.paddr,   16'h4010);
        chk("wr_setup_wdata", ifa.pwdata,  32'hDEADBEEF);
        chk("wr_setup_pwr",   ifa.pwrite,  1'b1);
        chk("wr_setup_ready", ifa.req_ready, 1'b0);
        tick;                                   // ACCESS
        chk("wr_acc_psel", ifa.psel,    4'b0010);
        chk("wr_acc_pen",  ifa.penable, 1'b1);
        chk("wr_acc_rsp",  ifa.rsp_valid, 1'b0);
        tick;                                   // response
        chk("wr_rsp_valid", ifa.rsp_valid, 1'b1);
        chk("wr_rsp_err",   ifa.rsp_err,   1'b0);
        chk("wr_rsp_rdata", ifa.rsp_rdata, 32'h0);
        chk("wr_end_psel",  ifa.psel,      4'b0000);
        chk("wr_end_pen",   ifa.penable,   1'b0);
        tick;
        chk("wr_rsp_pulse", ifa.rsp_valid, 1'b0);

        // ---------------- read slave 3 with 3 wait states ----------------
        ifa.pready = 4'b0000;
        ifa.prdata[127:96] = 32'h12345678;
        ifa.prdata[31:0]   = 32'hBAD0BAD0;
        req_a(1'b0, 16'hC004, 32'h0);
        tick;                                   // SETUP
        ifa.req_valid = 1'b0;
        ifa.pready = 4'b0111;                   // other slaves ready: ignored
        chk("rd_setup_psel", ifa.psel, 4'b1000);
        chk("rd_setup_pwr",  ifa.pwrite, 1'b0);
        for (int w = 0; w < 3; w++) begin
            tick;                               // ACCESS, waiting
            chk("rd_wait_psel", ifa.psel,    4'b1000);
            chk("rd_wait_pen",  ifa.penable, 1'b1);
            chk("rd_wait_addr", ifa.paddr,   16'hC004);
            chk("rd_wait_rsp",  ifa.rsp_valid, 1'b0);
        end
        tick;                                   // 4th ACCESS cycle, pready arrives
        ifa.pready = 4'b1000;
        #1;
        chk("rd_done_ready", ifa.req_ready, 1'b1);
        tick;
        ifa.pready = 4'b0000;
        chk("rd_rsp_valid", ifa.rsp_valid, 1'b1);
        chk("rd_rsp_rdata", ifa.rsp_rdata, 32'h12345678);
        chk("rd_rsp_err",   ifa.rsp_err,   1'b0);
        chk("rd_end_psel",  ifa.psel,      4'b0000);

        // ---------------- back-to-back: write slave 0, read slave 2 ----------------
        ifa.pready = 4'b1111;
        ifa.prdata[95:64] = 32'hAABBCCDD;
        req_a(1'b1, 16'h0008, 32'h11111111);
        tick;                                   // SETUP slave 0
        req_a(1'b0, 16'h8020, 32'h0);           // offered early; not accepted in SETUP
        #1;
        chk("b2b_setup_ready", ifa.req_ready, 1'b0);
        tick;                                   // ACCESS slave 0, completion + accept
        chk("b2b_acc_psel", ifa.psel, 4'b0001);
        chk("b2b_acc_ready", ifa.req_ready, 1'b1);
        tick;                                   // SETUP slave 2 + first response
        ifa.req_valid = 1'b0;
        chk("b2b_rsp1",      ifa.rsp_valid, 1'b1);
        chk("b2b_rsp1_data", ifa.rsp_rdata, 32'h0);
        chk("b2b_s2_psel",   ifa.psel,      4'b0100);
        chk("b2b_s2_pen",    ifa.penable,   1'b0);
        chk("b2b_s2_addr",   ifa.paddr,     16'h8020);
        tick;                                   // ACCESS slave 2
        chk("b2b_gap",       ifa.rsp_valid, 1'b0);
        chk("b2b_s2_acc",    ifa.penable,   1'b1);
        tick;
        chk("b2b_rsp2",      ifa.rsp_valid, 1'b1);
        chk("b2b_rsp2_data", ifa.rsp_rdata, 32'hAABBCCDD);

        // ---------------- timeout: pready never arrives ----------------
        ifa.pready = 4'b0000;
        ifa.prdata[63:32] = 32'h55AA55AA;
        req_a(1'b0, 16'h4000, 32'h0);
        tick;                                   // SETUP
        ifa.req_valid = 1'b0;
        for (int w = 0; w < 4; w++) begin
            tick;                               // 4 ACCESS cycles
            chk("to_acc_pen", ifa.penable, 1'b1);
        end
        #1;
        chk("to_abort_ready", ifa.req_ready, 1'b0);
        tick;
        chk("to_psel",  ifa.psel,      4'b0000);
        chk("to_pen",   ifa.penable,   1'b0);
        chk("to_rsp",   ifa.rsp_valid, 1'b1);
        chk("to_err",   ifa.rsp_err,   1'b1);
        chk("to_rdata", ifa.rsp_rdata, 32'h0);
        chk("to_ready", ifa.req_ready, 1'b1);

        // ---------------- pready on the timeout-limit cycle wins ----------------
        req_a(1'b0, 16'h4000, 32'h0);
        tick;                                   // SETUP
        ifa.req_valid = 1'b0;
        tick; tick; tick;                       // ACCESS 1..3
        tick;                                   // ACCESS 4
        ifa.pready = 4'b0010;
        tick;
        ifa.pready = 4'b0000;
        chk("tolim_rsp",   ifa.rsp_valid, 1'b1);
        chk("tolim_err",   ifa.rsp_err,   1'b0);
        chk("tolim_rdata", ifa.rsp_rdata, 32'h55AA55AA);

        // ---------------- pslverr forwarding ----------------
        ifa.pready  = 4'b1111;
        ifa.pslverr = 4'b0010;
        req_a(1'b0, 16'h4004, 32'h0);
        tick;
        ifa.req_valid = 1'b0;
        tick;
        tick;
        ifa.pslverr = 4'b0000;
        chk("slverr_rsp",   ifa.rsp_valid, 1'b1);
        chk("slverr_err",   ifa.rsp_err,   1'b1);
        chk("slverr_rdata", ifa.rsp_rdata, 32'h0);

        // ---------------- reset during ACCESS ----------------
        ifa.pready = 4'b0000;
        req_a(1'b0, 16'h8000, 32'h0);
        tick;
        ifa.req_valid = 1'b0;
        tick;                                   // ACCESS
        chk("rstacc_pen", ifa.penable, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("rstacc_psel",  ifa.psel,    4'b0000);
        chk("rstacc_pen0",  ifa.penable, 1'b0);
        chk("rstacc_paddr", ifa.paddr,   16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        ifa.pready = 4'b1111;
        tick;
        chk("rstacc_norsp1", ifa.rsp_valid, 1'b0);
        tick;
        chk("rstacc_norsp2", ifa.rsp_valid, 1'b0);
        req_a(1'b1, 16'h0000, 32'h0000BEEF);
        tick;
        ifa.req_valid = 1'b0;
        chk("rstacc_new_psel", ifa.psel, 4'b0001);
        tick;
        tick;
        chk("rstacc_new_rsp", ifa.rsp_valid, 1'b1);
        chk("rstacc_new_err", ifa.rsp_err,   1'b0);
        ifa.pready = 4'b0000;

        // ---------------- B: decode error from IDLE ----------------
        req_b(1'b1, 16'hC000, 32'h0);
        tick;
        ifb.req_valid = 1'b0;
        chk("dec_psel",  ifb.psel,      3'b000);
        chk("dec_rsp",   ifb.rsp_valid, 1'b1);
        chk("dec_err",   ifb.rsp_err,   1'b1);
        chk("dec_rdata", ifb.rsp_rdata, 32'h0);
        chk("dec_ready", ifb.req_ready, 1'b1);
        tick;
        chk("dec_pulse", ifb.rsp_valid, 1'b0);

        // ---------------- B: back-to-back decode error ----------------
        ifb.pready = 3'b111;
        req_b(1'b1, 16'h8000, 32'h00000022);
        tick;                                   // SETUP slave 2
        req_b(1'b0, 16'hC000, 32'h0);
        chk("b2bdec_psel", ifb.psel, 3'b100);
        tick;                                   // ACCESS, completion + accept of bad idx
        #1;
        chk("b2bdec_acc_ready", ifb.req_ready, 1'b1);
        tick;
        ifb.req_valid = 1'b0;
        chk("b2bdec_rsp1",     ifb.rsp_valid, 1'b1);
        chk("b2bdec_rsp1_err", ifb.rsp_err,   1'b0);
        chk("b2bdec_psel0",    ifb.psel,      3'b000);
        tick;
        chk("b2bdec_rsp2",     ifb.rsp_valid, 1'b1);
        chk("b2bdec_rsp2_err", ifb.rsp_err,   1'b1);
        tick;
        chk("b2bdec_quiet", ifb.rsp_valid, 1'b0);
        chk("b2bdec_ready", ifb.req_ready, 1'b1);

        // ---------------- B: TIMEOUT=0 never aborts ----------------
        ifb.pready = 3'b000;
        ifb.prdata[31:0] = 32'hCAFEF00D;
        req_b(1'b0, 16'h0010, 32'h0);
        tick;
        ifb.req_valid = 1'b0;
        for (int w = 0; w < 8; w++) tick;
        chk("noto_pen", ifb.penable,   1'b1);
        chk("noto_rsp", ifb.rsp_valid, 1'b0);
        ifb.pready = 3'b001;
        tick;
        ifb.pready = 3'b000;
        chk("noto_done_rsp",   ifb.rsp_valid, 1'b1);
        chk("noto_done_rdata", ifb.rsp_rdata, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
